// File: rtl/mx_mdio_master.sv
// Clause 45 MDIO master: serialises one address/write/read frame per run_i rising edge.
// Optional build macro MX_MDIO_PRE_SUPPRESS_EN skips the preamble so frames start at ST.
module mx_mdio_master #(
    parameter int unsigned DIV_W   = 6,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             soft_rst_i,
    input  logic             run_i,
    input  logic [1:0]       cop_i,
    input  logic [DIV_W-1:0] divider_i,
    input  logic [4:0]       phy_addr_i,
    input  logic [4:0]       dev_addr_i,
    input  logic [15:0]      wr_data_i,
    output logic [15:0]      rd_data_o,
    output logic             rd_data_val_o,
    output logic             busy_o,
    output logic             mdc_o,
    output logic             mdio_o,
    output logic             mdio_oe_o,
    input  logic             mdio_i
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SR_W  = 32;
    localparam int unsigned RD_W  = 16;
`ifdef MX_MDIO_PRE_SUPPRESS_EN
    localparam int unsigned PRE_BITS = PRE_LEN * 0;
`else
    localparam int unsigned PRE_BITS = PRE_LEN;
`endif
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_BITS - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(13);
    localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(15);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_run, r_run_d;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [DIV_W-1:0]  r_div_cnt, w_div_cnt_nxt;
    logic              r_phase, w_phase_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [SR_W-1:0]   r_sr, w_sr_nxt;
    logic [RD_W-1:0]   r_rd_sh, w_rd_sh_nxt;
    logic              r_read, w_read_nxt;
    logic [15:0]       w_rd_data_nxt;
    logic              w_rd_val_nxt, w_busy_nxt, w_mdc_nxt, w_mdio_nxt, w_oe_nxt;
    logic              w_start, w_half_end, w_rise, w_bit_end, w_emit, w_drv;
    logic [SR_W-1:0]   w_frame;

    assign w_start = r_run & ~r_run_d;
    assign w_frame = {2'b00, cop_i, phy_addr_i, dev_addr_i, 2'b10, wr_data_i};

    // run_i edge detector; deliberately untouched by soft reset so a held run_i cannot relaunch
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run   <= 1'b0;
            r_run_d <= 1'b0;
        end else begin
            r_run   <= run_i;
            r_run_d <= r_run;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE; r_div <= '0; r_div_cnt <= '0; r_phase <= 1'b0;
            r_bit_cnt <= '0; r_sr <= '0; r_rd_sh <= '0; r_read <= 1'b0;
            rd_data_o <= '0; rd_data_val_o <= 1'b0; busy_o <= 1'b0;
            mdc_o <= 1'b0; mdio_o <= 1'b1; mdio_oe_o <= 1'b0;
        end else if (soft_rst_i) begin
            r_state <= S_IDLE; r_div <= '0; r_div_cnt <= '0; r_phase <= 1'b0;
            r_bit_cnt <= '0; r_sr <= '0; r_rd_sh <= '0; r_read <= 1'b0;
            rd_data_o <= '0; rd_data_val_o <= 1'b0; busy_o <= 1'b0;
            mdc_o <= 1'b0; mdio_o <= 1'b1; mdio_oe_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt; r_div <= w_div_nxt; r_div_cnt <= w_div_cnt_nxt;
            r_phase <= w_phase_nxt; r_bit_cnt <= w_bit_cnt_nxt; r_sr <= w_sr_nxt;
            r_rd_sh <= w_rd_sh_nxt; r_read <= w_read_nxt;
            rd_data_o <= w_rd_data_nxt; rd_data_val_o <= w_rd_val_nxt; busy_o <= w_busy_nxt;
            mdc_o <= w_mdc_nxt; mdio_o <= w_mdio_nxt; mdio_oe_o <= w_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_div_cnt_nxt = r_div_cnt;
        w_phase_nxt   = r_phase;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sr_nxt      = r_sr;
        w_rd_sh_nxt   = r_rd_sh;
        w_read_nxt    = r_read;
        w_rd_data_nxt = rd_data_o;
        w_rd_val_nxt  = rd_data_val_o;
        w_busy_nxt    = busy_o;
        w_mdc_nxt     = mdc_o;
        w_mdio_nxt    = mdio_o;
        w_oe_nxt      = mdio_oe_o;
        w_emit        = 1'b0;
        w_drv         = 1'b0;
        w_half_end    = (r_div_cnt == r_div);
        w_rise        = (r_state != S_IDLE) && !r_phase && w_half_end;
        w_bit_end     = (r_state != S_IDLE) && r_phase && w_half_end;

        // MDC half-period timer: low half then high half, each divider+1 cycles
        if (r_state != S_IDLE) begin
            if (w_half_end) begin
                w_div_cnt_nxt = '0;
                w_phase_nxt   = ~r_phase;
                w_mdc_nxt     = ~r_phase;
            end else begin
                w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
            end
        end

        if (w_rise && (r_state == S_DATA)) begin
            w_rd_sh_nxt = {r_rd_sh[RD_W-2:0], mdio_i};
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_div_nxt     = divider_i;
                    w_read_nxt    = cop_i[1];
                    w_busy_nxt    = 1'b1;
                    w_rd_val_nxt  = 1'b0;
                    w_oe_nxt      = 1'b1;
                    w_div_cnt_nxt = '0;
                    w_phase_nxt   = 1'b0;
                    w_mdc_nxt     = 1'b0;
                    if (PRE_BITS == 0) begin
                        w_state_nxt   = S_HDR;
                        w_bit_cnt_nxt = HDR_LAST;
                        w_mdio_nxt    = w_frame[SR_W-1];
                        w_sr_nxt      = {w_frame[SR_W-2:0], 1'b0};
                    end else begin
                        w_state_nxt   = S_PRE;
                        w_bit_cnt_nxt = PRE_LAST;
                        w_mdio_nxt    = 1'b1;
                        w_sr_nxt      = w_frame;
                    end
                end
            end
            S_PRE: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == '0) begin
                        w_state_nxt   = S_HDR;
                        w_bit_cnt_nxt = HDR_LAST;
                        w_emit        = 1'b1;
                        w_drv         = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                    end
                end
            end
            S_HDR: begin
                if (w_bit_end) begin
                    w_emit = 1'b1;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt   = S_TA;
                        w_bit_cnt_nxt = TA_LAST;
                        w_drv         = ~r_read;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                        w_drv         = 1'b1;
                    end
                end
            end
            S_TA: begin
                if (w_bit_end) begin
                    w_emit = 1'b1;
                    w_drv  = ~r_read;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = DATA_LAST;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == '0) begin
                        w_state_nxt   = S_DONE;
                        w_bit_cnt_nxt = '0;
                        w_oe_nxt      = 1'b0;
                        w_mdio_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                        w_emit        = 1'b1;
                        w_drv         = ~r_read;
                    end
                end
            end
            S_DONE: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (r_read) begin
                        w_rd_data_nxt = r_rd_sh;
                        w_rd_val_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // bit start: drive the next frame bit, or release the line during read turnaround/data
        if (w_emit) begin
            w_mdio_nxt = w_drv ? r_sr[SR_W-1] : 1'b1;
            w_oe_nxt   = w_drv;
            w_sr_nxt   = {r_sr[SR_W-2:0], 1'b0};
        end
    end

endmodule
